// File: rtl/brg_slave_xcel_dispatch.sv
// Bridge-slave dispatcher: forwards one endpoint request at a time to the
// accelerator selected by an address field, waits for its return, then acks
// the endpoint and presents the result one cycle later. Unmapped selects and
// accelerators that stall too long are answered with dead_data_p and flagged.
//
// state | meaning
// IDLE  | waiting for an endpoint request
// ISSUE | xcel_v_o[idx] asserted, waiting for the accelerator to take it
// WAIT  | accelerator took the request, waiting for its return valid
// ACK   | in_yumi_o pulse to the endpoint
// RET   | returning_v_o pulse with the captured data
module brg_slave_xcel_dispatch #(
  parameter int data_width_p = 32,
  parameter int addr_width_p = 32,
  parameter int num_xcel_p   = 3,
  parameter int sel_lsb_p    = 10,
  parameter int timeout_p    = 255,
  parameter logic [data_width_p-1:0] dead_data_p = 'hDEAD_BEEF
) (
  input  logic                               clk_i,
  input  logic                               reset_i,
  input  logic                               in_v_i,
  input  logic [addr_width_p-1:0]            in_addr_i,
  input  logic [data_width_p-1:0]            in_data_i,
  input  logic [data_width_p/8-1:0]          in_mask_i,
  input  logic                               in_we_i,
  output logic                               in_yumi_o,
  output logic                               returning_v_o,
  output logic [data_width_p-1:0]            returning_data_o,
  output logic [num_xcel_p-1:0]              xcel_v_o,
  output logic [addr_width_p-1:0]            xcel_addr_o,
  output logic [data_width_p-1:0]            xcel_data_o,
  output logic [data_width_p/8-1:0]          xcel_mask_o,
  output logic                               xcel_we_o,
  input  logic [num_xcel_p-1:0]              xcel_yumi_i,
  input  logic [num_xcel_p-1:0]              xcel_ret_v_i,
  input  logic [num_xcel_p*data_width_p-1:0] xcel_ret_data_i,
  output logic                               busy_o,
  output logic                               err_unmapped_o,
  output logic                               err_timeout_o
);

  localparam int sel_w  = (num_xcel_p > 1) ? $clog2(num_xcel_p) : 1;
  localparam int mask_w = data_width_p / 8;
  localparam int cnt_w  = $clog2(timeout_p + 1);

  localparam logic [sel_w:0]     num_xcel_c = (sel_w + 1)'(num_xcel_p);
  localparam logic [cnt_w-1:0]   tmo_last_c = cnt_w'(timeout_p - 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, ACK, RET} state_e;

  state_e state_r, state_n;

  logic [addr_width_p-1:0] addr_r;
  logic [data_width_p-1:0] data_r;
  logic [mask_w-1:0]       mask_r;
  logic                    we_r;
  logic [sel_w-1:0]        idx_r;
  logic [cnt_w-1:0]        cnt_r;
  logic [data_width_p-1:0] cap_r;
  logic [data_width_p-1:0] ret_data_r;
  logic                    err_unmapped_r;
  logic                    err_timeout_r;

  logic [sel_w-1:0]        in_idx;
  logic                    in_mapped;
  logic                    sel_yumi;
  logic                    sel_ret_v;
  logic [data_width_p-1:0] sel_ret_data;
  logic                    timed_out;

  logic                    load_req;
  logic                    cnt_clr;
  logic                    cnt_inc;
  logic                    cap_en;
  logic [data_width_p-1:0] cap_d;
  logic                    set_unmapped;
  logic                    set_timeout;

  assign in_idx    = in_addr_i[sel_lsb_p +: sel_w];
  assign in_mapped = ({1'b0, in_idx} < num_xcel_c);
  assign timed_out = (cnt_r == tmo_last_c);

  // Pick out the handshake and return data of the latched target only.
  always_comb begin
    sel_yumi     = 1'b0;
    sel_ret_v    = 1'b0;
    sel_ret_data = '0;
    for (int i = 0; i < num_xcel_p; i++) begin
      if (idx_r == sel_w'(i)) begin
        sel_yumi     = xcel_yumi_i[i];
        sel_ret_v    = xcel_ret_v_i[i];
        sel_ret_data = xcel_ret_data_i[i*data_width_p +: data_width_p];
      end
    end
  end

  // Next-state and datapath strobes; a completing return beats the timeout.
  always_comb begin
    state_n      = state_r;
    load_req     = 1'b0;
    cnt_clr      = 1'b0;
    cnt_inc      = 1'b0;
    cap_en       = 1'b0;
    cap_d        = '0;
    set_unmapped = 1'b0;
    set_timeout  = 1'b0;
    case (state_r)
      IDLE: begin
        if (in_v_i) begin
          load_req = 1'b1;
          if (in_mapped) begin
            cnt_clr = 1'b1;
            state_n = ISSUE;
          end else begin
            cap_en       = 1'b1;
            cap_d        = dead_data_p;
            set_unmapped = 1'b1;
            state_n      = ACK;
          end
        end
      end
      ISSUE: begin
        cnt_inc = 1'b1;
        if (sel_yumi && sel_ret_v) begin
          cap_en  = 1'b1;
          cap_d   = sel_ret_data;
          state_n = ACK;
        end else if (timed_out) begin
          cap_en      = 1'b1;
          cap_d       = dead_data_p;
          set_timeout = 1'b1;
          state_n     = ACK;
        end else if (sel_yumi) begin
          state_n = WAIT;
        end
      end
      WAIT: begin
        cnt_inc = 1'b1;
        if (sel_ret_v) begin
          cap_en  = 1'b1;
          cap_d   = sel_ret_data;
          state_n = ACK;
        end else if (timed_out) begin
          cap_en      = 1'b1;
          cap_d       = dead_data_p;
          set_timeout = 1'b1;
          state_n     = ACK;
        end
      end
      ACK:     state_n = RET;
      RET:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_r <= IDLE;
    else         state_r <= state_n;
  end

  // Request fields are latched once on acceptance and drive the shared xcel bus.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      addr_r <= '0;
      data_r <= '0;
      mask_r <= '0;
      we_r   <= 1'b0;
      idx_r  <= '0;
    end else if (load_req) begin
      addr_r <= in_addr_i;
      data_r <= in_data_i;
      mask_r <= in_mask_i;
      we_r   <= in_we_i;
      idx_r  <= in_idx;
    end
  end

  // Cycles spent in ISSUE+WAIT for the current request.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)      cnt_r <= '0;
    else if (cnt_clr) cnt_r <= '0;
    else if (cnt_inc) cnt_r <= cnt_r + cnt_w'(1);
  end

  // Capture the response, then copy it to the endpoint as RET begins so the
  // returned value stays stable between responses.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cap_r      <= '0;
      ret_data_r <= '0;
    end else begin
      if (cap_en)           cap_r      <= cap_d;
      if (state_r == ACK)   ret_data_r <= cap_r;
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      err_unmapped_r <= 1'b0;
      err_timeout_r  <= 1'b0;
    end else begin
      if (set_unmapped) err_unmapped_r <= 1'b1;
      if (set_timeout)  err_timeout_r  <= 1'b1;
    end
  end

  // Per-xcel valid is a one-hot decode of the latched index, only in ISSUE.
  always_comb begin
    xcel_v_o = '0;
    for (int i = 0; i < num_xcel_p; i++) begin
      xcel_v_o[i] = (state_r == ISSUE) && (idx_r == sel_w'(i));
    end
  end

  assign xcel_addr_o      = addr_r;
  assign xcel_data_o      = data_r;
  assign xcel_mask_o      = mask_r;
  assign xcel_we_o        = we_r;
  assign in_yumi_o        = (state_r == ACK);
  assign returning_v_o    = (state_r == RET);
  assign returning_data_o = ret_data_r;
  assign busy_o           = (state_r != IDLE);
  assign err_unmapped_o   = err_unmapped_r;
  assign err_timeout_o    = err_timeout_r;

endmodule

// File: tb/tb_brg_slave_xcel_dispatch.sv
// Bench for the dispatcher: directed scenarios followed by random requests.
// Expected timing comes from a transaction-level model: with the target taking
// the request yd cycles into ISSUE and returning rd cycles later, completion
// is at min(yd+rd, T-1) and the endpoint sees yumi/return two/three cycles on.
module tb_brg_slave_xcel_dispatch;

  localparam int          T    = 8;
  localparam logic [31:0] DEAD = 32'hDEAD_BEEF;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        in_v_i;
  logic [31:0] in_addr_i;
  logic [31:0] in_data_i;
  logic [3:0]  in_mask_i;
  logic        in_we_i;
  logic        in_yumi_o;
  logic        returning_v_o;
  logic [31:0] returning_data_o;
  logic [2:0]  xcel_v_o;
  logic [31:0] xcel_addr_o;
  logic [31:0] xcel_data_o;
  logic [3:0]  xcel_mask_o;
  logic        xcel_we_o;
  logic [2:0]  xcel_yumi_i;
  logic [2:0]  xcel_ret_v_i;
  logic [95:0] xcel_ret_data_i;
  logic        busy_o;
  logic        err_unmapped_o;
  logic        err_timeout_o;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_ret = '0;
  bit          m_unm = 1'b0;
  bit          m_tmo = 1'b0;

  brg_slave_xcel_dispatch #(.timeout_p(T)) dut (
    .clk_i            (clk_i),
    .reset_i          (reset_i),
    .in_v_i           (in_v_i),
    .in_addr_i        (in_addr_i),
    .in_data_i        (in_data_i),
    .in_mask_i        (in_mask_i),
    .in_we_i          (in_we_i),
    .in_yumi_o        (in_yumi_o),
    .returning_v_o    (returning_v_o),
    .returning_data_o (returning_data_o),
    .xcel_v_o         (xcel_v_o),
    .xcel_addr_o      (xcel_addr_o),
    .xcel_data_o      (xcel_data_o),
    .xcel_mask_o      (xcel_mask_o),
    .xcel_we_o        (xcel_we_o),
    .xcel_yumi_i      (xcel_yumi_i),
    .xcel_ret_v_i     (xcel_ret_v_i),
    .xcel_ret_data_i  (xcel_ret_data_i),
    .busy_o           (busy_o),
    .err_unmapped_o   (err_unmapped_o),
    .err_timeout_o    (err_timeout_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic noise();
    xcel_yumi_i     = 3'($urandom());
    xcel_ret_v_i    = 3'($urandom());
    xcel_ret_data_i = {$urandom(), $urandom(), $urandom()};
  endtask

  task automatic idle_cycles(input int n, input bit force0);
    int bad = 0;
    for (int c = 0; c < n; c++) begin
      @(posedge clk_i); #1;
      in_v_i = 1'b0;
      noise();
      if (force0) xcel_ret_v_i[0] = 1'b1;
      @(negedge clk_i);
      if ({busy_o, in_yumi_o, returning_v_o, xcel_v_o} !== 6'd0 || returning_data_o !== last_ret) bad++;
    end
    chk("idle_quiet", 64'(bad), 64'd0);
  endtask

  task automatic run_txn(input string tag, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] mask, input logic we, input int yd, input int rd,
                         input logic [31:0] rdata, input bit hold_next);
    int          idx, jc, vend, exp_y, exp_r;
    bit          mapped, tmo, seen_y;
    logic [31:0] exp_data, got_data;
    logic [2:0]  exp_v;
    int          bad_y, bad_r, bad_v, bad_b, bad_h;
    idx    = int'((addr >> 10) & 32'd3);
    mapped = (idx < 3);
    if (mapped) begin
      tmo      = (yd + rd > T - 1);
      jc       = tmo ? T - 1 : yd + rd;
      vend     = (yd > T - 1) ? T - 1 : yd;
      exp_y    = jc + 2;
      exp_r    = jc + 3;
      exp_data = tmo ? DEAD : rdata;
    end else begin
      tmo      = 1'b0;
      jc       = 0;
      vend     = -1;
      exp_y    = 1;
      exp_r    = 2;
      exp_data = DEAD;
    end
    seen_y = 1'b0; got_data = '0;
    bad_y = 0; bad_r = 0; bad_v = 0; bad_b = 0; bad_h = 0;
    for (int c = 0; c <= exp_r; c++) begin
      @(posedge clk_i); #1;
      if (!seen_y) begin
        in_v_i = 1'b1; in_addr_i = addr; in_data_i = data; in_mask_i = mask; in_we_i = we;
      end else if (hold_next) begin
        in_v_i = 1'b1; in_data_i = $urandom();
      end else begin
        in_v_i = 1'b0;
      end
      noise();
      if (mapped) begin
        xcel_yumi_i[idx]  = 1'b0;
        xcel_ret_v_i[idx] = 1'b0;
        if (c >= 1 && c - 1 == yd) xcel_yumi_i[idx] = 1'b1;
        if (c >= 1 && c - 1 == yd + rd) begin
          xcel_ret_v_i[idx] = 1'b1;
          xcel_ret_data_i[idx*32 +: 32] = rdata;
        end
      end
      @(negedge clk_i);
      exp_v = '0;
      if (mapped && c >= 1 && c - 1 <= vend) exp_v[idx] = 1'b1;
      if (xcel_v_o !== exp_v) bad_v++;
      if (in_yumi_o !== (c == exp_y)) bad_y++;
      if (returning_v_o !== (c == exp_r)) bad_r++;
      if (busy_o !== (c != 0)) bad_b++;
      if (c < exp_r && returning_data_o !== last_ret) bad_h++;
      if (c == 1 && mapped)
        chk({tag, "_fields"}, 64'({xcel_addr_o, xcel_data_o}), 64'({addr, data}));
      if (c == 1 && mapped)
        chk({tag, "_mask_we"}, 64'({xcel_mask_o, xcel_we_o}), 64'({mask, we}));
      if (c == exp_r) got_data = returning_data_o;
      if (in_yumi_o === 1'b1) seen_y = 1'b1;
    end
    if (tmo)     m_tmo = 1'b1;
    if (!mapped) m_unm = 1'b1;
    chk({tag, "_yumi_timing"}, 64'(bad_y), 64'd0);
    chk({tag, "_ret_timing"},  64'(bad_r), 64'd0);
    chk({tag, "_xcel_v"},      64'(bad_v), 64'd0);
    chk({tag, "_busy"},        64'(bad_b), 64'd0);
    chk({tag, "_data_hold"},   64'(bad_h), 64'd0);
    chk({tag, "_ret_data"},    64'(got_data), 64'(exp_data));
    chk({tag, "_err_flags"},   64'({err_unmapped_o, err_timeout_o}), 64'({m_unm, m_tmo}));
    last_ret = exp_data;
  endtask

  initial begin
    logic [31:0] a;
    bit          hold;
    reset_i = 1'b1;
    in_v_i = 1'b0; in_addr_i = '0; in_data_i = '0; in_mask_i = '0; in_we_i = 1'b0;
    xcel_yumi_i = '0; xcel_ret_v_i = '0; xcel_ret_data_i = '0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_busy",   64'(busy_o), 64'd0);
    chk("rst_pulses", 64'({in_yumi_o, returning_v_o, xcel_v_o}), 64'd0);
    chk("rst_rdata",  64'(returning_data_o), 64'd0);
    chk("rst_flags",  64'({err_unmapped_o, err_timeout_o}), 64'd0);
    chk("rst_fields", 64'({xcel_addr_o, xcel_mask_o, xcel_we_o}), 64'd0);
    @(posedge clk_i); #1;
    reset_i = 1'b0;
    idle_cycles(2, 1'b0);

    run_txn("read_x1",   32'h0000_0404, 32'h0,         4'hF, 1'b0, 1, 2, 32'h1234, 1'b0);
    idle_cycles(1, 1'b0);
    run_txn("unmapped",  32'h0000_0C00, 32'hA5A5_0001, 4'h3, 1'b1, 0, 0, 32'h0,    1'b0);
    idle_cycles(1, 1'b0);
    run_txn("same_cyc",  32'h0000_0000, 32'h0,         4'hF, 1'b0, 0, 0, 32'h55,   1'b0);
    run_txn("last_win",  32'h0000_0400, 32'h1111_2222, 4'hC, 1'b1, 5, 2, 32'hCAFE_0001, 1'b0);
    run_txn("last_same", 32'h0000_0800, 32'h3333_4444, 4'h1, 1'b0, 7, 0, 32'hCAFE_0002, 1'b0);
    run_txn("tmo_wait",  32'h0000_0400, 32'h5555_6666, 4'h2, 1'b0, 6, 2, 32'hCAFE_0003, 1'b0);
    run_txn("tmo_issue", 32'h0000_0000, 32'h7777_8888, 4'hF, 1'b1, 99, 0, 32'hCAFE_0004, 1'b0);
    idle_cycles(3, 1'b1);
    run_txn("b2b_a",     32'h0000_0800, 32'h0000_00A1, 4'hF, 1'b1, 1, 1, 32'hB2B0_0001, 1'b1);
    run_txn("b2b_b",     32'h0000_0800, 32'h0000_00B2, 4'hF, 1'b1, 0, 2, 32'hB2B0_0002, 1'b0);

    // Reset while the request sits in WAIT.
    @(posedge clk_i); #1;
    in_v_i = 1'b1; in_addr_i = 32'h0000_0404; in_data_i = 32'h0; in_mask_i = 4'hF; in_we_i = 1'b0;
    xcel_yumi_i = '0; xcel_ret_v_i = '0;
    @(posedge clk_i); #1;
    xcel_yumi_i = 3'b010;
    @(posedge clk_i); #1;
    xcel_yumi_i = 3'b000;
    #2;
    reset_i = 1'b1;
    in_v_i  = 1'b0;
    #1;
    chk("rstw_busy",   64'(busy_o), 64'd0);
    chk("rstw_pulses", 64'({in_yumi_o, returning_v_o, xcel_v_o}), 64'd0);
    chk("rstw_rdata",  64'(returning_data_o), 64'd0);
    chk("rstw_flags",  64'({err_unmapped_o, err_timeout_o}), 64'd0);
    chk("rstw_fields", 64'({xcel_addr_o, xcel_data_o}), 64'd0);
    @(posedge clk_i); #1;
    xcel_ret_v_i = 3'b010; xcel_ret_data_i = {3{32'h1234_5678}};
    @(posedge clk_i); #1;
    xcel_ret_v_i = 3'b000;
    reset_i = 1'b0;
    last_ret = '0; m_unm = 1'b0; m_tmo = 1'b0;
    idle_cycles(3, 1'b0);
    run_txn("post_rst",  32'h0000_0404, 32'h0, 4'hF, 1'b0, 1, 1, 32'h0BAD_F00D, 1'b0);

    hold = 1'b0;
    for (int k = 0; k < 40; k++) begin
      a = $urandom();
      a[11:10] = 2'($urandom_range(0, 3));
      hold = ($urandom_range(0, 1) == 1);
      run_txn("rand", a, $urandom(), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
              int'($urandom_range(0, 9)), int'($urandom_range(0, 3)), $urandom(), hold);
      if (!hold && $urandom_range(0, 3) == 0) idle_cycles(1, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/brg_slave_xcel_dispatch.md
BRG_SLAVE_XCEL_DISPATCH -- requirements
Module: brg_slave_xcel_dispatch

Interface
REQ-001 SHALL have parameter data_width_p, default 32, meaning request/return data width.
REQ-002 SHALL have parameter addr_width_p, default 32, meaning request address width.
REQ-003 SHALL have parameter num_xcel_p, default 3, meaning number of slave accelerators; sel_w = clog2(num_xcel_p).
REQ-004 SHALL have parameter sel_lsb_p, default 10, meaning LSB of the xcel-select field, idx = in_addr_i[sel_lsb_p +: sel_w].
REQ-005 SHALL have parameter timeout_p, default 255, meaning max cycles spent in ISSUE+WAIT.
REQ-006 SHALL have parameter dead_data_p, default 32'hDEAD_BEEF, meaning error return data.
REQ-007 SHALL have ports, in order: clk_i  in  1  clock; reset_i  in  1  asynchronous active-high reset.
REQ-008 SHALL have ports: in_v_i  in  1; in_addr_i  in  addr_width_p; in_data_i  in  data_width_p; in_mask_i  in  data_width_p/8; in_we_i  in  1 (endpoint slave request, held until yumi).
REQ-009 SHALL have ports: in_yumi_o  out  1; returning_v_o  out  1; returning_data_o  out  data_width_p (endpoint slave response).
REQ-010 SHALL have ports: xcel_v_o  out  num_xcel_p; xcel_addr_o  out  addr_width_p; xcel_data_o  out  data_width_p; xcel_mask_o  out  data_width_p/8; xcel_we_o  out  1 (shared fields, per-xcel valid).
REQ-011 SHALL have ports: xcel_yumi_i  in  num_xcel_p; xcel_ret_v_i  in  num_xcel_p; xcel_ret_data_i  in  num_xcel_p*data_width_p (xcel i at slice i).
REQ-012 SHALL have ports: busy_o  out  1 (state != IDLE); err_unmapped_o  out  1 (sticky); err_timeout_o  out  1 (sticky).

Function
REQ-013 SHALL implement FSM states IDLE, ISSUE, WAIT, ACK, RET; one request in flight.
REQ-014 IDLE: on in_v_i, SHALL latch addr/data/mask/we/idx; idx < num_xcel_p -> ISSUE, else -> ACK with data dead_data_p and err_unmapped_o set.
REQ-015 ISSUE: SHALL assert xcel_v_o[idx] only, with latched fields on xcel_*_o; on xcel_yumi_i[idx] -> WAIT.
REQ-016 ISSUE with xcel_yumi_i[idx] and xcel_ret_v_i[idx] in the same cycle SHALL capture return data and go directly to ACK.
REQ-017 WAIT: on xcel_ret_v_i[idx] SHALL capture xcel_ret_data_i slice idx -> ACK; reads and writes both complete via ret_v.
REQ-018 ACK: SHALL assert in_yumi_o for exactly one cycle -> RET.
REQ-019 RET: SHALL assert returning_v_o for exactly one cycle with captured data -> IDLE; endpoint sees returning_v_o exactly one cycle after in_yumi_o.
REQ-020 Timeout counter width clog2(timeout_p+1); SHALL clear on IDLE->ISSUE and increment each cycle in ISSUE/WAIT.
REQ-021 Timeout: if the counter equals timeout_p-1 in ISSUE/WAIT with no completion that cycle, SHALL go to ACK with dead_data_p and set err_timeout_o; completion in that same cycle wins.
REQ-022 xcel_ret_v_i from non-selected xcels, or outside ISSUE/WAIT, SHALL be ignored.
REQ-023 xcel_v_o SHALL be all-zero outside ISSUE; in_v_i SHALL be ignored in ISSUE, WAIT and RET.
REQ-024 returning_data_o SHALL hold its last value when returning_v_o is low.
REQ-025 Sticky error flags SHALL clear only on reset.

Reset
REQ-026 On reset_i assertion, SHALL go immediately to IDLE; all outputs 0, counter 0, captured data 0, flags 0, including mid-transaction; the aborted request is never acked.

Verification
REQ-027 Read addr 0x404 (idx 1): xcel1 yumi next cycle, ret 0x1234 2 cycles later -> one in_yumi_o pulse, then returning_v_o with 0x1234; xcel_v_o[0], xcel_v_o[2] never high.
REQ-028 Addr 0xC00 (idx 3, unmapped): in_yumi_o the cycle after IDLE, then returning_data_o=0xDEADBEEF, err_unmapped_o=1, xcel_v_o stays 0.
REQ-029 timeout_p=8, xcel0 never yumis -> xcel_v_o[0] high 8 cycles, then ACK/RET with 0xDEADBEEF, err_timeout_o=1; later xcel0 ret_v ignored.
REQ-030 Same-cycle yumi+ret (data 0x55) in ISSUE -> WAIT skipped; in_yumi_o next cycle; returning 0x55.
REQ-031 reset_i asserted in WAIT -> outputs 0 immediately; no in_yumi_o/returning_v_o; next request after reset served normally.
REQ-032 Back-to-back writes to xcel2 with in_v_i held -> second accepted only after first's RET; both return xcel2 ret data in order.
